// File: rtl/piso_shift_register_if.sv
// Load handshake and serial output bundle for piso_shift_register.
// The master drives the word and the load request. The slave (the shifter) returns ready and the serial stream.
interface piso_shift_register_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] A;
    logic             load;
    logic             ready;
    logic             sout;
    logic             valid;
    logic             last;

    modport master (
        output A, load,
        input  ready, sout, valid, last
    );

    modport slave (
        input  A, load,
        output ready, sout, valid, last
    );
endinterface

// File: rtl/piso_shift_register.sv
// Parallel-in / serial-out transmitter: captures a word on load && ready and emits it one bit per clock.
// The serial stream carries registered valid and last markers.
module piso_shift_register #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    piso_shift_register_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] shreg, shreg_d, sh_next;
    logic [CW-1:0]    cnt, cnt_d, cnt_inc;
    logic             sout_q, sout_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             ready;
    logic             accept;
    logic             at_last;

    assign ready   = (state == IDLE) || (valid_q && last_q);
    assign accept  = bus.load && ready;
    assign at_last = (cnt == LAST_IDX);
    assign cnt_inc = cnt + CW'(1);
    assign sh_next = MSB_FIRST ? (shreg << 1) : (shreg >> 1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (at_last && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next value of the registered stream and datapath.
    // The first bit is presented straight from A on the accepting edge, so shreg keeps the whole word.
    always_comb begin
        shreg_d = shreg;
        cnt_d   = cnt;
        sout_d  = 1'b0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        if (accept) begin
            shreg_d = bus.A;
            cnt_d   = '0;
            sout_d  = MSB_FIRST ? bus.A[WIDTH-1] : bus.A[0];
            valid_d = 1'b1;
            last_d  = (WIDTH == 1);
        end else if (state == SHIFT && !at_last) begin
            shreg_d = sh_next;
            cnt_d   = cnt_inc;
            sout_d  = MSB_FIRST ? sh_next[WIDTH-1] : sh_next[0];
            valid_d = 1'b1;
            last_d  = (cnt_inc == LAST_IDX);
        end else begin
            shreg_d = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            cnt     <= '0;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            shreg   <= shreg_d;
            cnt     <= cnt_d;
            sout_q  <= sout_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign bus.ready = ready;
    assign bus.sout  = sout_q;
    assign bus.valid = valid_q;
    assign bus.last  = last_q;
endmodule

// File: tb/tb_piso_shift_register.sv
// Directed bench for piso_shift_register covering LSB-first and MSB-first operation at WIDTH=4 and operation at WIDTH=1.
module tb_piso_shift_register;
    logic clk;
    logic rst;
    int   ncmp;
    int   nerr;

    piso_shift_register_if #(.WIDTH(4)) b4l ();
    piso_shift_register_if #(.WIDTH(4)) b4m ();
    piso_shift_register_if #(.WIDTH(1)) b1 ();

    piso_shift_register #(.WIDTH(4), .MSB_FIRST(1'b0)) u4l (.clk(clk), .rst(rst), .bus(b4l));
    piso_shift_register #(.WIDTH(4), .MSB_FIRST(1'b1)) u4m (.clk(clk), .rst(rst), .bus(b4m));
    piso_shift_register #(.WIDTH(1), .MSB_FIRST(1'b0)) u1  (.clk(clk), .rst(rst), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_l;
        logic [3:0] exp_m;
        logic [7:0] exp_s;
        ncmp = 0;
        nerr = 0;
        rst = 1'b1;
        b4l.A = '0; b4l.load = 1'b0;
        b4m.A = '0; b4m.load = 1'b0;
        b1.A  = '0; b1.load  = 1'b0;
        tick();
        tick();
        chk("rst_sout", b4l.sout, 1'b0);
        chk("rst_valid", b4l.valid, 1'b0);
        chk("rst_last", b4l.last, 1'b0);
        chk("rst_ready", b4l.ready, 1'b1);
        chk("rst1_valid", b1.valid, 1'b0);
        chk("rst1_ready", b1.ready, 1'b1);
        rst = 1'b0;
        tick();

        // Word 1011 sent LSB-first (1,1,0,1) and MSB-first (1,0,1,1) in parallel
        exp_l = 4'b1011;
        exp_m = 4'b1101;
        b4l.A = 4'b1011; b4l.load = 1'b1;
        b4m.A = 4'b1011; b4m.load = 1'b1;
        tick();
        b4l.load = 1'b0; b4m.load = 1'b0;
        b4l.A = 4'b0000; b4m.A = 4'b0000;
        for (int unsigned i = 0; i < 4; i++) begin
            chk($sformatf("lsb_sout%0d", i), b4l.sout, exp_l[i]);
            chk($sformatf("lsb_valid%0d", i), b4l.valid, 1'b1);
            chk($sformatf("lsb_last%0d", i), b4l.last, i == 3);
            chk($sformatf("msb_sout%0d", i), b4m.sout, exp_m[i]);
            chk($sformatf("msb_last%0d", i), b4m.last, i == 3);
            if (i == 0) chk("lsb_ready_busy", b4l.ready, 1'b0);
            tick();
        end
        chk("lsb_idle_valid", b4l.valid, 1'b0);
        chk("lsb_idle_sout", b4l.sout, 1'b0);
        chk("lsb_idle_ready", b4l.ready, 1'b1);
        chk("msb_idle_valid", b4m.valid, 1'b0);

        // Back-to-back: 1001 then 0110 loaded on the last-bit cycle
        exp_s = 8'b0110_1001;
        b4l.A = 4'b1001; b4l.load = 1'b1;
        tick();
        b4l.load = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            chk($sformatf("b2b_sout%0d", i), b4l.sout, exp_s[i]);
            chk($sformatf("b2b_valid%0d", i), b4l.valid, 1'b1);
            chk($sformatf("b2b_last%0d", i), b4l.last, (i == 3) || (i == 7));
            if (i == 3) begin
                chk("b2b_ready_last", b4l.ready, 1'b1);
                b4l.A = 4'b0110; b4l.load = 1'b1;
            end
            tick();
            b4l.load = 1'b0;
        end
        chk("b2b_end_valid", b4l.valid, 1'b0);

        // Load of 1111 issued mid-word is ignored
        b4l.A = 4'b0000; b4l.load = 1'b1;
        tick();
        b4l.load = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            chk($sformatf("ign_sout%0d", i), b4l.sout, 1'b0);
            chk($sformatf("ign_valid%0d", i), b4l.valid, 1'b1);
            if (i == 2) begin
                b4l.A = 4'b1111; b4l.load = 1'b1;
            end
            tick();
            b4l.load = 1'b0;
        end
        chk("ign_idle_valid", b4l.valid, 1'b0);
        chk("ign_idle_ready", b4l.ready, 1'b1);
        chk("ign_idle_sout", b4l.sout, 1'b0);

        // Reset mid-word aborts it; a load held during reset is dropped
        b4l.A = 4'b1111; b4l.load = 1'b1;
        tick();
        b4l.load = 1'b0;
        tick();
        chk("abort_pre_valid", b4l.valid, 1'b1);
        rst = 1'b1;
        tick();
        chk("abort_sout", b4l.sout, 1'b0);
        chk("abort_valid", b4l.valid, 1'b0);
        chk("abort_last", b4l.last, 1'b0);
        chk("abort_ready", b4l.ready, 1'b1);
        b4l.load = 1'b1;
        tick();
        rst = 1'b0;
        b4l.load = 1'b0;
        tick();
        chk("abort_after_valid", b4l.valid, 1'b0);
        chk("abort_after_sout", b4l.sout, 1'b0);
        tick();
        chk("abort_after2_valid", b4l.valid, 1'b0);

        // WIDTH=1: two consecutive accepted loads
        b1.A = 1'b1; b1.load = 1'b1;
        tick();
        chk("w1_sout0", b1.sout, 1'b1);
        chk("w1_valid0", b1.valid, 1'b1);
        chk("w1_last0", b1.last, 1'b1);
        chk("w1_ready0", b1.ready, 1'b1);
        b1.A = 1'b0;
        tick();
        b1.load = 1'b0;
        chk("w1_sout1", b1.sout, 1'b0);
        chk("w1_valid1", b1.valid, 1'b1);
        chk("w1_last1", b1.last, 1'b1);
        tick();
        chk("w1_idle_valid", b1.valid, 1'b0);
        chk("w1_idle_last", b1.last, 1'b0);
        chk("w1_idle_sout", b1.sout, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
